imp_cal_var: RTL and testbench

- Statistics stage directly upstream of the integer square-root stage in the improved LayerNorm datapath.
- Accepts a vector of N signed samples over a valid/ready stream and accumulates the sum and the sum of squares.
- Produces the floored mean and the variance. The variance is 16-bit unsigned, with negative results clamped to 0.
- On completion, pulses o_sqrt_start with o_var stable, so the square-root stage can latch o_var as its i_data.

---
 rtl/imp_cal_var.sv | 146 ++++++++++++++
 tb/tb_imp_cal_var.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imp_cal_var.sv
// Sum / sum-of-squares statistics ahead of the integer sqrt: floored mean and clamped 16-bit variance.
// Define IMP_VAR_EPS_EN to add EPS to the variance (saturating) so the sqrt result is never zero.
//
// state | meaning
// IDLE  | waiting for i_start, accumulators cleared on start
// ACC   | accepting N samples over valid/ready
// CALC  | mean/variance computed and registered
// DONE  | one-cycle done / sqrt-start pulse with o_var stable
module imp_cal_var #(
  parameter int          DW     = 8,
  parameter int          N_LOG2 = 3,
  parameter logic [15:0] EPS    = 16'd1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic [DW-1:0] o_mean,
  output logic [15:0]   o_var,
  output logic          o_sqrt_start,
  output logic          o_done,
  output logic          o_busy
);

  localparam int SW = DW + N_LOG2;
  localparam int QW = 2 * DW + N_LOG2;
  localparam int VW = 2 * DW + N_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [SW-1:0]   sum;
  logic        [QW-1:0]   sumsq;
  logic        [N_LOG2-1:0] count;

  logic                   accept;
  logic signed [DW-1:0]   sample;
  logic signed [2*DW-1:0] sample_sq;

  logic signed [DW-1:0]   mean_calc;
  logic signed [2*DW-1:0] mean_sq;
  logic        [2*DW-1:0] ex2;
  logic signed [VW-1:0]   var_raw;
  logic        [15:0]     var_clamp;
  logic        [15:0]     var_final;

  assign sample    = $signed(i_data);
  assign sample_sq = sample * sample;
  assign accept    = (state == ACC) && i_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = ACC;
      end
      ACC: begin
        o_ready = 1'b1;
        if (i_valid && (count == {N_LOG2{1'b1}})) state_nxt = CALC;
      end
      CALC: state_nxt = DONE;
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_sqrt_start = o_done;

  // Arithmetic shift by N_LOG2 then truncation to DW; the floored mean always fits in DW.
  assign mean_calc = sum[SW-1:N_LOG2];
  assign mean_sq   = mean_calc * mean_calc;
  assign ex2       = sumsq[QW-1:N_LOG2];
  assign var_raw   = $signed({{(VW-2*DW){1'b0}}, ex2}) - $signed({{(VW-2*DW){mean_sq[2*DW-1]}}, mean_sq});

  always_comb begin
    var_clamp = var_raw[15:0];
    if (var_raw < 0)
      var_clamp = 16'd0;
    else if (var_raw > $signed({{(VW-16){1'b0}}, 16'hFFFF}))
      var_clamp = 16'hFFFF;
  end

`ifdef IMP_VAR_EPS_EN
  logic [16:0] var_eps;
  assign var_eps   = {1'b0, var_clamp} + {1'b0, EPS};
  assign var_final = var_eps[16] ? 16'hFFFF : var_eps[15:0];
`else
  wire unused_eps = ^EPS;
  assign var_final = var_clamp;
`endif

  wire unused_lsbs = ^{sum[N_LOG2-1:0], sumsq[N_LOG2-1:0]};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sum    <= '0;
      sumsq  <= '0;
      count  <= '0;
      o_mean <= '0;
      o_var  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            sum   <= '0;
            sumsq <= '0;
            count <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            sum   <= sum + {{N_LOG2{sample[DW-1]}}, sample};
            sumsq <= sumsq + {{N_LOG2{1'b0}}, sample_sq};
            count <= count + 1'b1;
          end
        end
        CALC: begin
          o_mean <= mean_calc;
          o_var  <= var_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imp_cal_var.sv
// Randomised and directed bench for imp_cal_var against an arithmetic mean/variance model.
module tb_imp_cal_var;

  localparam int DW     = 8;
  localparam int N_LOG2 = 3;
  localparam int N      = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready, sqrt_start, done, busy;
  logic [DW-1:0] mean;
  logic [15:0]   var_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imp_cal_var #(.DW(DW), .N_LOG2(N_LOG2), .EPS(16'd1)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_valid      (valid),
    .i_data       (data),
    .o_ready      (ready),
    .o_mean       (mean),
    .o_var        (var_o),
    .o_sqrt_start (sqrt_start),
    .o_done       (done),
    .o_busy       (busy)
  );

  // Plain integer statistics: floor division for the mean, E[x^2] - mean^2, clamp to 16 bits.
  function automatic void model(input int s[N], output int m, output int v);
    int total = 0;
    int sq = 0;
    for (int i = 0; i < N; i++) begin
      total += s[i];
      sq    += s[i] * s[i];
    end
    m = (total >= 0) ? total / N : -((-total + N - 1) / N);
    v = sq / N - m * m;
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
`ifdef IMP_VAR_EPS_EN
    v = v + 1;
    if (v > 65535) v = 65535;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input int s[N], input int gap_min, input int gap_max,
                            input bit start_noise, input string name);
    int m, v;
    logic [DW-1:0] em;
    logic [15:0]   ev;
    model(s, m, v);
    em = m[DW-1:0];
    ev = v[15:0];
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
    for (int i = 0; i < N; i++) begin
      int gaps;
      gaps = (gap_min == gap_max) ? gap_min : int'($urandom_range(gap_max, gap_min));
      for (int g = 0; g < gaps; g++) begin
        valid = 1'b0;
        start = start_noise;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL %s ready_in_stall got=%b exp=1", name, ready); end
        step();
        start = 1'b0;
      end
      valid = 1'b1;
      data  = s[i][DW-1:0];
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL %s ready_sample%0d got=%b exp=1", name, i, ready); end
      step();
      valid = 1'b0;
    end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s calc_cycle done=%b busy=%b exp done=0 busy=1", name, done, busy); end
    step();
    checks++; if (done !== 1'b1 || sqrt_start !== 1'b1) begin failures++; $display("FAIL %s done_pulse done=%b sqrt_start=%b exp 1/1", name, done, sqrt_start); end
    checks++; if (mean !== em) begin failures++; $display("FAIL %s mean got=%0d exp=%0d", name, $signed(mean), m); end
    checks++; if (var_o !== ev) begin failures++; $display("FAIL %s var got=%0d exp=%0d", name, var_o, v); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL %s back_to_idle done=%b busy=%b ready=%b exp 0/0/0", name, done, busy, ready); end
    checks++; if (var_o !== ev || mean !== em) begin failures++; $display("FAIL %s held mean=%0d var=%0d exp %0d/%0d", name, $signed(mean), var_o, m, v); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({ready, busy, done, sqrt_start, mean, var_o} !== '0) begin failures++; $display("FAIL reset_state ready=%b busy=%b done=%b mean=%0d var=%0d exp all 0", ready, busy, done, mean, var_o); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed();
    int s[N];
    s = '{default: 5};
    run_vector(s, 0, 0, 1'b0, "fives");
    s = '{0, 2, 0, 2, 0, 2, 0, 2};
    run_vector(s, 0, 0, 1'b0, "zero_two");
    s = '{-128, 127, -128, 127, -128, 127, -128, 127};
    run_vector(s, 0, 0, 1'b0, "extremes");
    s = '{default: -128};
    run_vector(s, 0, 0, 1'b0, "all_min");
    s = '{-1, 0, 0, 0, 0, 0, 0, 0};
    run_vector(s, 0, 0, 1'b0, "neg_clamp");
  endtask

  task automatic test_stall_and_start_noise();
    int s[N];
    s = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_vector(s, 1, 1, 1'b1, "stall_1to8");
  endtask

  task automatic test_async_reset();
    int s[N];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      data  = 8'd7;
      step();
    end
    valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++; if ({ready, busy, done, mean, var_o} !== '0) begin failures++; $display("FAIL async_reset ready=%b busy=%b done=%b mean=%0d var=%0d exp all 0", ready, busy, done, mean, var_o); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    s = '{default: 5};
    run_vector(s, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int s[N];
    logic [DW-1:0] r;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N; i++) begin
        r = DW'($urandom);
        if (k % 6 == 5) r = ($urandom_range(1, 0) != 0) ? 8'h80 : 8'h7F;
        s[i] = int'($signed(r));
      end
      run_vector(s, 0, 3, (k % 2) == 1, "random");
    end
  endtask

  task automatic test_back_to_back();
    int s[N];
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) s[i] = int'($urandom_range(40, 0)) - 20;
      run_vector(s, 0, 0, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_and_start_noise();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
